// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and bubble-count constants for id_hazard_ctrl
package hazard_pkg;
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [1:0] BUBBLE_LOAD_BR = 2'd2;
  localparam logic [1:0] BUBBLE_ALU_BR = 2'd1;
  localparam logic [1:0] BUBBLE_LOAD_MEM_BR = 2'd1;
  localparam logic [1:0] BUBBLE_LOAD_USE = 2'd1;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/hazard_stats.sv
// hazard_stats: saturating stall/event counters, built only under HAZARD_STATS_EN
module hazard_stats #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              load_use,
  input  logic              branch_stall,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [15:0]       load_use_events,
  output logic [15:0]       branch_stall_events
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      load_use_events <= '0;
      branch_stall_events <= '0;
    end else begin
      if (hazard && !(&stall_cycles)) stall_cycles <= stall_cycles + STAT_W'(1);
      if (load_use && !(&load_use_events)) load_use_events <= load_use_events + 16'd1;
      if (branch_stall && !(&branch_stall_events)) branch_stall_events <= branch_stall_events + 16'd1;
    end
  end
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage hazard detection, branch-operand stalls and EX/MEM forwarding selects.
// Statistics counters are built only when HAZARD_STATS_EN is defined; otherwise they read 0.
module id_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int STAT_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_BITS-1:0] IDRs,
  input  logic [REG_BITS-1:0] IDRt,
  input  logic                IDUsesRt,
  input  logic                IDBranch,
  input  logic                IDEXRegWrite,
  input  logic                IDEXMemRead,
  input  logic                IDEXRegDst,
  input  logic [REG_BITS-1:0] IDEXRt,
  input  logic [REG_BITS-1:0] IDEXRd,
  input  logic                EXMEMRegWrite,
  input  logic                EXMEMMemRead,
  input  logic [REG_BITS-1:0] EXMEMDst,
  output logic                Hazard,
  output logic                PCWrite,
  output logic                IFIDWrite,
  output logic                BranchValid,
  output logic                forward1,
  output logic                forward2,
  output logic [STAT_W-1:0]   StallCycles,
  output logic [15:0]         LoadUseEvents,
  output logic [15:0]         BranchStallEvents
);
  localparam logic [REG_BITS-1:0] ZERO = REG_BITS'(ZERO_REG);
  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt, n;
  logic [REG_BITS-1:0] ex_dst;
  logic ex_match, mem_match, mem_fwd, run;
  assign ex_dst = IDEXRegDst ? IDEXRd : IDEXRt;
  assign ex_match = IDEXRegWrite && ex_dst != ZERO && (ex_dst == IDRs || (IDUsesRt && ex_dst == IDRt));
  assign mem_match = EXMEMRegWrite && EXMEMDst != ZERO && (EXMEMDst == IDRs || (IDUsesRt && EXMEMDst == IDRt));
  assign mem_fwd = EXMEMRegWrite && !EXMEMMemRead && EXMEMDst != ZERO;
  assign forward1 = mem_fwd && EXMEMDst == IDRs;
  assign forward2 = mem_fwd && EXMEMDst == IDRt;
  assign run = state == RUN;
  // First matching rule wins; branches need operands ready in ID, not EX
  always_comb
    n = (IDBranch && IDEXMemRead && ex_match) ? BUBBLE_LOAD_BR :
        (IDBranch && ex_match) ? BUBBLE_ALU_BR :
        (IDBranch && EXMEMMemRead && mem_match) ? BUBBLE_LOAD_MEM_BR :
        (!IDBranch && IDEXMemRead && ex_match) ? BUBBLE_LOAD_USE : 2'd0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // cnt holds the bubbles still owed after the current one
  always_comb begin
    state_nxt = run ? (n == BUBBLE_LOAD_BR ? STALL : RUN) : (cnt == 2'd1 ? RUN : STALL);
    cnt_nxt = run ? (n == BUBBLE_LOAD_BR ? n - 2'd1 : cnt) : cnt - 2'd1;
  end
  always_comb begin
    Hazard = run ? n != 2'd0 : 1'b1;
    PCWrite = run && n == 2'd0;
    IFIDWrite = PCWrite;
    BranchValid = PCWrite;
  end
`ifdef HAZARD_STATS_EN
  hazard_stats #(.STAT_W(STAT_W)) u_stats (
    .clk(clock),
    .rst(reset),
    .hazard(Hazard),
    .load_use(run && !IDBranch && n != 2'd0),
    .branch_stall(run && IDBranch && n != 2'd0),
    .stall_cycles(StallCycles),
    .load_use_events(LoadUseEvents),
    .branch_stall_events(BranchStallEvents)
  );
`else
  assign StallCycles = '0;
  assign LoadUseEvents = '0;
  assign BranchStallEvents = '0;
`endif
endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard-detection and ID-forwarding controller for the 5-stage pipeline. Drives the decode stage's `Hazard` bubble input and its `forward1`/`forward2` compare-operand selects, and freezes the PC and IF/ID register. Branches resolve in ID, so the block holds a branch until its operands are available. Stall sequencing is a registered FSM with a bubble counter, so multi-cycle stalls are exact.

## Interface
Parameters:
- `REG_BITS`, 5: register-specifier width.
- `STAT_W`, 32: width of the stall-cycle counter.

Ports:
- `clock` in 1: pipeline clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `IDRs`, `IDRt` in `REG_BITS`: source specifiers of the instruction in ID.
- `IDUsesRt` in 1: the ID instruction reads rt (R-type, beq, sw).
- `IDBranch` in 1: the ID instruction is a conditional branch.
- `IDEXRegWrite`, `IDEXMemRead`, `IDEXRegDst` in 1: ID/EX control.
- `IDEXRt`, `IDEXRd` in `REG_BITS`: ID/EX specifiers.
- `EXMEMRegWrite`, `EXMEMMemRead` in 1: EX/MEM control.
- `EXMEMDst` in `REG_BITS`: EX/MEM destination.
- `Hazard` out 1: inject a bubble into ID/EX this edge.
- `PCWrite` out 1: PC may update.
- `IFIDWrite` out 1: IF/ID may update.
- `BranchValid` out 1: ID branch outcome is trustworthy. IF ANDs it with `IFIDFlush`.
- `forward1`, `forward2` out 1: select the EX/MEM ALU result for ID compare operand 1 or 2.
- `StallCycles` out `STAT_W`: statistics (see Configuration).
- `LoadUseEvents`, `BranchStallEvents` out 16: statistics (see Configuration).

## Operation
- EX destination: `exDst = IDEXRegDst ? IDEXRd : IDEXRt`.
- An ID/EX entry is a producer only if `IDEXRegWrite` is set and `exDst` is not 0.
- An EX/MEM entry is a producer only if `EXMEMRegWrite` is set and `EXMEMDst` is not 0.
- Register 0 never matches.
- Source match: `IDRs`, or `IDRt` when `IDUsesRt` is set.
- Required bubbles N, evaluated in RUN only; the first matching rule wins:
  - `IDBranch`, load in EX matching a source: N=2.
  - `IDBranch`, ALU op in EX matching a source: N=1.
  - `IDBranch`, load in EX/MEM matching a source: N=1.
  - Not a branch, load in EX matching a source (load-use): N=1.
  - Otherwise: N=0.
- FSM states, encoded in `hazard_pkg`:
  - RUN: outputs `Hazard = (N!=0)`, `PCWrite = IFIDWrite = (N==0)`, `BranchValid = (N==0)`. N==2 loads `cnt=1` and moves to STALL; N<=1 stays in RUN, since the dependency has cleared by the next cycle.
  - STALL: outputs `Hazard=1`, `PCWrite=0`, `IFIDWrite=0`, `BranchValid=0`. `cnt` decrements; at `cnt==1` it goes to RUN next cycle.
- Forwarding is combinational in every state:
  - `forward1 = EXMEMRegWrite & ~EXMEMMemRead & EXMEMDst!=0 & EXMEMDst==IDRs`.
  - `forward2` is the same with `IDRt`.
- Register-file write-through for MEM/WB is the register file's responsibility; this block never forwards from MEM/WB.

## Timing
- Reset values: state=RUN, `cnt=0`, all statistics 0. Combinational outputs follow from RUN.
- Reset asserted in STALL: the next cycle is RUN, with detection re-evaluated from scratch.
- Stall latency by N:
  - N=1: one bubble; ID instruction advances on the following edge.
  - N=2: two consecutive bubbles; the PC is held for 2 edges.
- No new detection in STALL. The held instruction is re-checked on the first RUN cycle.
- `BranchValid` low whenever `Hazard` is high, so no flush happens on stale compare data.

## Configuration
- `HAZARD_STATS_EN` defined: saturating counters, cleared by `reset`.
  - `StallCycles` increments on every cycle with `Hazard` high.
  - `LoadUseEvents` increments on each RUN entry to a non-branch load-use stall.
  - `BranchStallEvents` increments on each RUN detection with `IDBranch` and N>0.
- Undefined: statistics ports remain and are driven 0; no counter logic is built.

## Structure
- `hazard_pkg` holds:
  - the state enum (RUN, STALL);
  - the bubble-count constants (`BUBBLE_LOAD_BR=2`, `BUBBLE_ALU_BR=1`, `BUBBLE_LOAD_USE=1`);
  - the zero-register constant.
- One sub-module, `hazard_stats`, holds the counters. It is instantiated only under `HAZARD_STATS_EN`.

## Test plan
- lw $2 in EX with `IDEXMemRead=1`, `IDEXRt=2`; add $3,$2,$4 in ID → `Hazard=1`, `PCWrite=0` for exactly 1 cycle, then RUN.
- lw $2 in EX; beq $2,$5 in ID → `Hazard` high 2 cycles, `BranchValid=0` both cycles, `BranchValid=1` on cycle 3.
- add $7 in EX/MEM (`EXMEMDst=7`, `MemRead=0`); beq $7,$7 in ID → `forward1=forward2=1`, `Hazard=0`.
- ALU writes $0 in EX; beq $0,$1 in ID → no stall, `forward1=0`.
- `reset` pulsed in the STALL cycle of a load-branch stall → next cycle `Hazard=0`, `PCWrite=1`, and with stats on, all counters read 0.
- With `HAZARD_STATS_EN`, run the load-branch stall, then a load-use stall → `StallCycles=3`, `BranchStallEvents=1`, `LoadUseEvents=1`.
